// File: rtl/triangle_fetch.sv
`timescale 1ns/1ps
// triangle_fetch
//   Producer side of the triangle FIFO. Walks a contiguous triangle table in
//   model BRAM (one 152-bit word per triangle) and drives the FIFO's three
//   write streams: position, normal and material. The FIFO write side has no
//   ready, so flow control is credit based. `used` counts every FIFO slot that
//   is spoken for, which is reads in flight plus FIFO occupancy. A read is
//   issued only while used < FIFO_DEPTH-1, so the FIFO can never overfill.
//
//   Optional feature macro: TRIANGLE_FETCH_CULL_EN
//     When it is defined, triangles whose material is 12'hFFF are dropped and
//     their credit is returned. When it is undefined, every triangle is written.
//
//   Handshake: there is no valid/ready pair on this block. A read is
//   requested by mem_en_out with mem_addr_out. Its data is taken from
//   mem_data_in exactly MEM_LATENCY cycles later. The three write strobes
//   assert together for one cycle per triangle and carry no backpressure.
//   consume_in is one FIFO pop per cycle.
//
//   Ports:
//     clk_in, rst_in            clock, async active-high reset
//     start_in                  job start (IDLE only); latches base_addr_in/tri_count_in
//     busy_out, done_out        not-IDLE flag, one-cycle completion pulse
//     mem_en_out, mem_addr_out  BRAM read request
//     mem_data_in               BRAM data {position[127:0], normal[11:0], material[11:0]}
//     position_/normal_/material_(valid_)out  FIFO write streams
//     consume_in                FIFO pop pulse (returns one credit)
//     emitted_count_out         triangles written in the current job
//     state_out, used_out       debug view of FSM state and credit counter
module triangle_fetch #(
    parameter int ADDR_W      = 12,
    parameter int COUNT_W     = 12,
    parameter int MEM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4096
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic [ADDR_W-1:0]            base_addr_in,
    input  logic [COUNT_W-1:0]           tri_count_in,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         mem_en_out,
    output logic [ADDR_W-1:0]            mem_addr_out,
    input  logic [151:0]                 mem_data_in,
    output logic                         position_valid_out,
    output logic [127:0]                 position_out,
    output logic                         normal_valid_out,
    output logic [11:0]                  normal_out,
    output logic                         material_valid_out,
    output logic [11:0]                  material_out,
    input  logic                         consume_in,
    output logic [COUNT_W-1:0]           emitted_count_out,
    output logic [1:0]                   state_out,
    output logic [$clog2(FIFO_DEPTH):0]  used_out
);

    localparam int USED_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [USED_W-1:0] USED_MAX = USED_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [ADDR_W-1:0]      addr_q;
    logic [COUNT_W-1:0]     remaining_q;
    logic [COUNT_W-1:0]     emitted_q;
    logic [USED_W-1:0]      used_q, used_d;
    logic [MEM_LATENCY-1:0] vld_q, vld_d;
    logic                   wr_q;
    logic [151:0]           data_q;

    logic                   issue;
    logic                   arrive;
    logic                   cull;
    logic                   wr_d;
    logic                   consume_ok;
    logic [USED_W:0]        used_inc, used_dec;

    assign issue  = (state_q == ISSUE) && (remaining_q != '0) && (used_q < USED_MAX);
    // The oldest pipeline bit lines up with the cycle where mem_data_in is valid.
    assign arrive = vld_q[MEM_LATENCY-1];

`ifdef TRIANGLE_FETCH_CULL_EN
    assign cull = arrive && (mem_data_in[11:0] == 12'hFFF);
`else
    assign cull = 1'b0;
`endif

    assign wr_d       = arrive && !cull;
    assign consume_ok = consume_in && (used_q != '0);

    // A culled arrival releases its reserved slot straight away. A pop with
    // no credits held is ignored, so the counter saturates at zero.
    always_comb begin
        used_inc = {1'b0, used_q} + {{USED_W{1'b0}}, issue};
        used_dec = {{USED_W{1'b0}}, cull} + {{USED_W{1'b0}}, consume_ok};
        used_d   = (used_inc > used_dec) ? USED_W'(used_inc - used_dec) : '0;
    end

    always_comb begin
        vld_d = (vld_q << 1) | MEM_LATENCY'(issue);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_in) state_d = (tri_count_in != '0) ? ISSUE : DONE;
            ISSUE: if (issue && (remaining_q == COUNT_W'(1))) state_d = DRAIN;
            // The last write strobe is being driven in the first cycle where
            // nothing is left in the read pipeline.
            DRAIN: if (vld_q == '0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            emitted_q   <= '0;
            used_q      <= '0;
            vld_q       <= '0;
            wr_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            vld_q   <= vld_d;
            wr_q    <= wr_d;
            if (state_q == IDLE && start_in) begin
                addr_q      <= base_addr_in;
                remaining_q <= tri_count_in;
                emitted_q   <= '0;
            end else if (issue) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
            if (wr_d) begin
                data_q    <= mem_data_in;
                emitted_q <= emitted_q + 1'b1;
            end
        end
    end

    assign busy_out           = (state_q != IDLE);
    assign done_out           = (state_q == DONE);
    assign mem_en_out         = issue;
    assign mem_addr_out       = addr_q;
    assign position_valid_out = wr_q;
    assign normal_valid_out   = wr_q;
    assign material_valid_out = wr_q;
    assign position_out       = data_q[151:24];
    assign normal_out         = data_q[23:12];
    assign material_out       = data_q[11:0];
    assign emitted_count_out  = emitted_q;
    assign state_out          = state_q;
    assign used_out           = used_q;

endmodule
